wb_result_collector: RTL and testbench



---
 rtl/wb_result_collector.sv | 190 +++++++++++++++++++
 tb/tb_wb_result_collector.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_collector.sv
// wb_result_collector: receives the two-lane conv writeback stream, applies
// ReLU / shift / saturate quantization, generates ofmap addresses and
// serializes both lanes through an address/data FIFO onto a single-port
// memory write interface with backpressure.
module wb_result_collector #(
   parameter int DATA_WIDTH = 25,
   parameter int DEPTH      = 62,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 8,
   parameter int NUM_TILES  = 16,
   parameter int FIFO_DEPTH = 128,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] port0_data,
   input  logic                  port0_valid,
   input  logic [DATA_WIDTH-1:0] port1_data,
   input  logic                  port1_valid,
   input  logic                  odd_cnt,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [OUT_WIDTH-1:0]  mem_wr_data,
   input  logic                  mem_wr_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  proto_err
);

   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
   localparam int OW = ADDR_WIDTH - 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
   localparam int EW = ADDR_WIDTH + OUT_WIDTH;
   localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   col_reg;
   logic            pair_reg;
   logic [TW-1:0]   tile_reg;
   logic            beat_acc, last_beat, frame_start;

   logic [OW-1:0]   row0_w, off0_w, off1_w;

   logic            s1_v0_reg, s1_v1_reg;
   logic [ADDR_WIDTH-1:0] s1_addr0_reg, s1_addr1_reg;
   logic [OUT_WIDTH-1:0]  s1_data0_reg, s1_data1_reg;

   logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [NW-1:0]   fifo_cnt_reg, free_w;
   logic            pop, push0, push1, ovf_drop;
   logic [EW-1:0]   head_w;

   // ReLU, arithmetic shift (logical once negatives are zeroed), saturate.
   function automatic logic [OUT_WIDTH-1:0] quant(input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] q;
      q = x >> SHIFT;
      if (x[DATA_WIDTH-1]) return '0;
      if (|q[DATA_WIDTH-1:OUT_WIDTH]) return '1;
      return q[OUT_WIDTH-1:0];
   endfunction

   assign last_beat = (col_reg == CW'(DEPTH - 1)) && pair_reg &&
                      (tile_reg == TW'(NUM_TILES - 1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic, beat acceptance and frame-start strobe.
   always_comb begin
      state_next  = state_reg;
      frame_start = 1'b0;
      beat_acc    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next  = S_RUN;
               frame_start = 1'b1;
            end
         end
         S_RUN: begin
            if (port0_valid) begin
               beat_acc = 1'b1;
               if (last_beat) state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (fifo_cnt_reg == '0 && !s1_v0_reg && !s1_v1_reg) state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Column / pair / tile position of the next accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n || frame_start) begin
         col_reg  <= '0;
         pair_reg <= 1'b0;
         tile_reg <= '0;
      end else if (beat_acc) begin
         if (col_reg == CW'(DEPTH - 1)) begin
            col_reg  <= '0;
            pair_reg <= ~pair_reg;
            if (pair_reg) tile_reg <= tile_reg + TW'(1);
         end else begin
            col_reg <= col_reg + CW'(1);
         end
      end
   end

   // row0 = tile*4 + pair*2 is just the bit concatenation {tile, pair, 0}.
   assign row0_w = OW'({tile_reg, pair_reg, 1'b0});
   assign off0_w = row0_w * DEPTH_W + OW'(col_reg);
   assign off1_w = off0_w + DEPTH_W;

   // Stage S1: quantized data, bank-tagged addresses and lane valids.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v0_reg    <= 1'b0;
         s1_v1_reg    <= 1'b0;
         s1_addr0_reg <= '0;
         s1_addr1_reg <= '0;
         s1_data0_reg <= '0;
         s1_data1_reg <= '0;
      end else begin
         s1_v0_reg    <= beat_acc;
         s1_v1_reg    <= beat_acc & port1_valid;
         s1_addr0_reg <= {odd_cnt, off0_w};
         s1_addr1_reg <= {odd_cnt, off1_w};
         s1_data0_reg <= quant(port0_data);
         s1_data1_reg <= quant(port1_data);
      end
   end

   // Free space includes this cycle's pop; lane 1 only follows a pushed lane 0.
   assign pop      = (fifo_cnt_reg != '0) && mem_wr_ready;
   assign free_w   = NW'(FIFO_DEPTH) - fifo_cnt_reg + NW'(pop);
   assign push0    = s1_v0_reg && (free_w != '0);
   assign push1    = s1_v1_reg && push0 && (free_w >= NW'(2));
   assign ovf_drop = (s1_v0_reg && !push0) || (s1_v1_reg && !push1);

   // FIFO storage: lane 0 lands at the write pointer, lane 1 right after it.
   always_ff @(posedge clk) begin
      if (push0) fifo_mem[wr_ptr_reg]          <= {s1_addr0_reg, s1_data0_reg};
      if (push1) fifo_mem[wr_ptr_reg + PW'(1)] <= {s1_addr1_reg, s1_data1_reg};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fifo_cnt_reg <= '0;
      end else begin
         wr_ptr_reg   <= wr_ptr_reg + PW'(push0) + PW'(push1);
         rd_ptr_reg   <= rd_ptr_reg + PW'(pop);
         fifo_cnt_reg <= fifo_cnt_reg + NW'(push0) + NW'(push1) - NW'(pop);
      end
   end

   // Sticky error flags, cleared when a new frame starts.
   always_ff @(posedge clk) begin
      if (!rst_n || frame_start) begin
         overflow  <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (ovf_drop) overflow <= 1'b1;
         if (state_reg == S_RUN && port1_valid && !port0_valid) proto_err <= 1'b1;
      end
   end

   // Head is masked while empty so the port reads zero instead of stale RAM.
   assign head_w      = fifo_mem[rd_ptr_reg];
   assign mem_wr_en   = (fifo_cnt_reg != '0);
   assign mem_wr_addr = mem_wr_en ? head_w[EW-1:OUT_WIDTH] : '0;
   assign mem_wr_data = mem_wr_en ? head_w[OUT_WIDTH-1:0]  : '0;
   assign busy        = (state_reg == S_RUN) || (state_reg == S_DRAIN);
   assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_wb_result_collector.sv
// Directed testbench for wb_result_collector: full single-tile frame,
// quantization corners, latency, protocol error, bank bit, reset mid-burst,
// backpressure and overflow (on a small-FIFO instance).
module tb_wb_result_collector;

   logic        clk = 1'b0;
   logic        rst_n;

   // main instance (DEPTH=62, single tile, 128-entry FIFO)
   logic        start, p0v, p1v, odd, ready;
   logic [24:0] p0d, p1d;
   logic        en, busy, done, ovf, perr;
   logic [15:0] addr;
   logic [7:0]  data;

   // small instance for overflow (DEPTH=2, 4-entry FIFO)
   logic        o_start, o_p0v, o_p1v, o_odd, o_ready;
   logic [24:0] o_p0d, o_p1d;
   logic        o_en, o_busy, o_done, o_ovf, o_perr;
   logic [15:0] o_addr;
   logic [7:0]  o_data;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [23:0] cap_q[$];
   logic [23:0] ocap_q[$];
   int          done_cnt = 0;
   int          o_done_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [23:0] held = '0;

   always #5 clk = ~clk;

   wb_result_collector #(.DEPTH(62), .NUM_TILES(1), .FIFO_DEPTH(128)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .port0_data(p0d), .port0_valid(p0v), .port1_data(p1d), .port1_valid(p1v),
      .odd_cnt(odd), .mem_wr_en(en), .mem_wr_addr(addr), .mem_wr_data(data),
      .mem_wr_ready(ready), .busy(busy), .done(done), .overflow(ovf), .proto_err(perr));

   wb_result_collector #(.DEPTH(2), .NUM_TILES(1), .FIFO_DEPTH(4)) dut_ovf (
      .clk(clk), .rst_n(rst_n), .start(o_start),
      .port0_data(o_p0d), .port0_valid(o_p0v), .port1_data(o_p1d), .port1_valid(o_p1v),
      .odd_cnt(o_odd), .mem_wr_en(o_en), .mem_wr_addr(o_addr), .mem_wr_data(o_data),
      .mem_wr_ready(o_ready), .busy(o_busy), .done(o_done), .overflow(o_ovf), .proto_err(o_perr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int x0, input logic v0, input int x1, input logic v1, input logic b);
      p0d = 25'(x0); p0v = v0; p1d = 25'(x1); p1v = v1; odd = b;
   endtask

   task automatic obeat(input int x0, input logic v0, input int x1, input logic v1);
      o_p0d = 25'(x0); o_p0v = v0; o_p1d = 25'(x1); o_p1v = v1; o_odd = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Memory-port monitor: captures writes and checks head stability under stall.
   always @(negedge clk) begin
      if (rst_n && en && ready) cap_q.push_back({addr, data});
      if (rst_n && o_en && o_ready) ocap_q.push_back({o_addr, o_data});
      if (rst_n && stall_prev && en) check("hold", 32'({addr, data}), 32'(held));
      stall_prev <= rst_n && en && !ready;
      held       <= {addr, data};
      if (done)   done_cnt   <= done_cnt + 1;
      if (o_done) o_done_cnt <= o_done_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int d0, d1, a0;
      rst_n = 1'b0; start = 0; ready = 0;
      beat(0, 0, 0, 0, 0);
      o_start = 0; o_ready = 0;
      obeat(0, 0, 0, 0);

      // ---- reset values ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_en",   32'(en),   0);
      check("rst_addr", 32'(addr), 0);
      check("rst_data", 32'(data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ovf",  32'(ovf),  0);
      check("rst_perr", 32'(perr), 0);
      tick();
      rst_n = 1'b1;

      // ---- full single-tile frame, ready=1, x = 256*k ----
      ready = 1; base = cap_q.size();
      tick(); start = 1; tick(); start = 0;
      check("t1_busy", 32'(busy), 1);
      for (int i = 0; i < 124; i++) begin
         beat(256 * (3 * i), 1, 256 * (3 * i + 1), 1, 0);
         tick();
      end
      beat(0, 0, 0, 0, 0);
      for (int n = 0; n < 600 && done_cnt == 0; n++) @(negedge clk);
      repeat (5) tick();
      check("t1_done_cnt", 32'(done_cnt), 1);
      check("t1_busy_end", 32'(busy), 0);
      check("t1_ovf", 32'(ovf), 0);
      check("t1_count", 32'(cap_q.size() - base), 248);
      if (cap_q.size() - base == 248) begin
         for (int i = 0; i < 124; i++) begin
            a0 = (i / 62) * 124 + (i % 62);
            d0 = (3 * i > 255) ? 255 : 3 * i;
            d1 = (3 * i + 1 > 255) ? 255 : 3 * i + 1;
            check("t1_lane0", 32'(cap_q[base + 2 * i]),     32'({16'(a0), 8'(d0)}));
            check("t1_lane1", 32'(cap_q[base + 2 * i + 1]), 32'({16'(a0 + 62), 8'(d1)}));
         end
      end

      // ---- quantization, latency, bank bit, proto error ----
      do_reset();
      ready = 1; base = cap_q.size();
      tick(); start = 1; tick(); start = 0;
      beat(-5, 1, 255, 1, 1);             // beat A, cycle t, bank 1
      tick();
      beat(256, 1, 32'h0FFFFFF, 1, 0);    // beat B, cycle t+1
      @(negedge clk);
      check("lat_t1_en", 32'(en), 0);
      tick();
      beat(0, 0, 0, 0, 0);
      @(negedge clk);
      check("lat_t2_en",   32'(en),   1);
      check("lat_t2_addr", 32'(addr), 32'h8000);
      tick();
      @(negedge clk);
      check("lat_t3_addr", 32'(addr), 32'h803E);
      repeat (4) tick();
      check("perr_before", 32'(perr), 0);
      beat(512, 0, 512, 1, 0);            // lane 1 without lane 0
      tick();
      beat(0, 0, 0, 0, 0);
      repeat (4) tick();
      check("perr_set", 32'(perr), 1);
      check("perr_nowrite", 32'(cap_q.size() - base), 4);
      beat(512, 1, 512, 0, 0);            // beat C: lane 0 only, col 2
      tick();
      beat(0, 0, 0, 0, 0);
      repeat (4) tick();
      check("q_count", 32'(cap_q.size() - base), 5);
      if (cap_q.size() - base == 5) begin
         check("q_neg",    32'(cap_q[base + 0]), 32'({16'h8000, 8'd0}));
         check("q_255",    32'(cap_q[base + 1]), 32'({16'h803E, 8'd0}));
         check("q_256",    32'(cap_q[base + 2]), 32'({16'd1,    8'd1}));
         check("q_sat",    32'(cap_q[base + 3]), 32'({16'd63,   8'd255}));
         check("q_col2",   32'(cap_q[base + 4]), 32'({16'd2,    8'd2}));
      end

      // ---- reset mid-burst ----
      ready = 0;
      for (int i = 0; i < 3; i++) begin
         beat(256, 1, 256, 1, 0);
         tick();
      end
      check("mid_en_before", 32'(en), 1);
      rst_n = 0;
      tick();
      rst_n = 1;
      beat(0, 0, 0, 0, 0);
      @(negedge clk);
      check("mid_en",   32'(en),   0);
      check("mid_busy", 32'(busy), 0);
      check("mid_perr", 32'(perr), 0);
      repeat (3) tick();
      check("mid_en_later", 32'(en), 0);

      // ---- backpressure: ready toggles 1010 during a 62-beat burst ----
      do_reset();
      base = cap_q.size(); ready = 1;
      tick(); start = 1; tick(); start = 0;
      for (int i = 0; i < 62; i++) begin
         beat(256 * i, 1, 256 * (i + 100), 1, 0);
         ready = ~ready;
         tick();
      end
      beat(0, 0, 0, 0, 0);
      for (int n = 0; n < 600 && cap_q.size() - base < 124; n++) begin
         ready = ~ready;
         tick();
      end
      ready = 1;
      repeat (3) tick();
      check("bp_ovf",   32'(ovf), 0);
      check("bp_count", 32'(cap_q.size() - base), 124);
      if (cap_q.size() - base == 124) begin
         for (int i = 0; i < 62; i++) begin
            check("bp_lane0", 32'(cap_q[base + 2 * i]),     32'({16'(i),      8'(i)}));
            check("bp_lane1", 32'(cap_q[base + 2 * i + 1]), 32'({16'(62 + i), 8'(i + 100)}));
         end
      end

      // ---- overflow on the 4-entry FIFO instance ----
      do_reset();
      o_ready = 0;
      tick(); o_start = 1; tick(); o_start = 0;
      obeat(256 * 10, 1, 256 * 11, 1); tick();
      obeat(256 * 12, 1, 256 * 13, 1); tick();
      obeat(256 * 14, 1, 256 * 15, 1); tick();
      obeat(0, 0, 0, 0);
      tick(); tick();
      @(negedge clk);
      check("ov_flag", 32'(o_ovf),  1);
      check("ov_en",   32'(o_en),   1);
      check("ov_head", 32'(o_addr), 0);
      tick();
      o_ready = 1;
      for (int n = 0; n < 20 && ocap_q.size() < 4; n++) tick();
      repeat (3) tick();
      check("ov_count", 32'(ocap_q.size()), 4);
      if (ocap_q.size() == 4) begin
         check("ov_e0", 32'(ocap_q[0]), 32'({16'd0, 8'd10}));
         check("ov_e1", 32'(ocap_q[1]), 32'({16'd2, 8'd11}));
         check("ov_e2", 32'(ocap_q[2]), 32'({16'd1, 8'd12}));
         check("ov_e3", 32'(ocap_q[3]), 32'({16'd3, 8'd13}));
      end
      check("ov_sticky", 32'(o_ovf), 1);
      obeat(256 * 16, 1, 256 * 17, 1); tick();   // last beat: col 1, pair 1
      obeat(0, 0, 0, 0);
      for (int n = 0; n < 50 && o_done_cnt == 0; n++) @(negedge clk);
      check("ov_done", 32'(o_done_cnt), 1);
      tick(); tick();
      check("ov_count2", 32'(ocap_q.size()), 6);
      if (ocap_q.size() == 6) begin
         check("ov_e4", 32'(ocap_q[4]), 32'({16'd5, 8'd16}));
         check("ov_e5", 32'(ocap_q[5]), 32'({16'd7, 8'd17}));
      end
      check("ov_after_frame", 32'(o_ovf), 1);
      o_start = 1; tick(); o_start = 0;
      @(negedge clk);
      check("ov_cleared", 32'(o_ovf), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
